// File: rtl/apb_mem_slave_if.sv
// APB3/APB4 bus bundle between a master and apb_mem_slave.
interface apb_mem_slave_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_slave.sv
// APB slave backed by a word-addressed register file with programmable wait states.
// Define APB_PSTRB_EN to honour per-byte write strobes; otherwise writes update the full word.
module apb_mem_slave #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    apb_mem_slave_if.slave  apb
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        WAIT_MAX = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_prdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_setup;
    logic                w_load;
    logic                w_commit;
    logic                w_pready;
    logic                w_pslverr;
    logic                w_in_range_req;
    logic                w_in_range_lat;
    logic [IDX_W-1:0]    w_idx_req;
    logic [IDX_W-1:0]    w_idx_lat;

    assign w_setup        = apb.psel & ~apb.penable;
    assign w_in_range_req = ({1'b0, apb.paddr} < DEPTH_L);
    assign w_in_range_lat = ({1'b0, r_addr} < DEPTH_L);
    assign w_idx_req      = apb.paddr[IDX_W-1:0];
    assign w_idx_lat      = r_addr[IDX_W-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, wait counting and transfer completion
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        w_pready    = 1'b0;
        w_pslverr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = 4'd0;
                    w_load      = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!apb.psel) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (!apb.penable) begin
                    w_cnt_nxt   = 4'd0;
                    w_load      = 1'b1;
                end else if (r_cnt == WAIT_MAX) begin
                    w_pready    = 1'b1;
                    w_pslverr   = ~w_in_range_lat;
                    w_commit    = r_write & w_in_range_lat;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Request capture; read data is fetched at setup so it is valid for every access cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_prdata <= '0;
        end else if (w_load) begin
            r_addr  <= apb.paddr;
            r_write <= apb.pwrite;
            if (!apb.pwrite) begin
                r_prdata <= w_in_range_req ? r_mem[w_idx_req] : '0;
            end
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
`ifdef APB_PSTRB_EN
                if (apb.pstrb[b]) begin
                    r_mem[w_idx_lat][b*8 +: 8] <= apb.pwdata[b*8 +: 8];
                end
`else
                r_mem[w_idx_lat][b*8 +: 8] <= apb.pwdata[b*8 +: 8];
`endif
            end
        end
    end

`ifndef APB_PSTRB_EN
    logic w_pstrb_unused;
    assign w_pstrb_unused = ^apb.pstrb;
`endif

    assign apb.prdata  = r_prdata;
    assign apb.pready  = w_pready;
    assign apb.pslverr = w_pslverr;
endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB3/APB4 slave with an internal word-addressed register file, programmable wait states via PREADY and error response via PSLVERR. Generalises the team's fixed 8-bit, 256-entry APB memory to configurable data width, depth and latency. Sits on the peripheral APB segment behind the bridge as scratch/config storage and as the reference target for APB master verification.

## Interface
- DATA_W, 32: data bus width; multiple of 8, range 8 to 64.
- ADDR_W, 8: paddr width; paddr is a word index, not a byte address.
- DEPTH, 256: implemented words, at most 2^ADDR_W.
- WAIT_CYCLES, 0: wait states inserted per transfer, range 0 to 15.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- psel  in  1  slave select.
- penable  in  1  access phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  word index.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  byte write strobes (APB4).
- prdata  out  DATA_W  read data, registered.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response; qualified by pready.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: on edge with psel=1, penable=0 (setup phase) -> ACCESS; wait counter cnt <= 0; paddr/pwrite latched; prdata <= mem[paddr] when pwrite=0 and paddr < DEPTH, else 0 when pwrite=0 and paddr >= DEPTH; prdata unchanged on writes. psel=1, penable=1 in IDLE (no setup seen): protocol violation, ignored, stay IDLE, pready=0.
- ACCESS, psel=1, penable=1: pready = (cnt == WAIT_CYCLES), combinational. If pready=0: cnt <= cnt+1, stay. If pready=1: transfer completes, write performed if pwrite=1 and in range, -> IDLE.
- ACCESS, psel=0: master abort -> IDLE, no write, no response.
- ACCESS, psel=1, penable=0: new setup restarts transfer exactly as from IDLE.
- Out of range (latched paddr >= DEPTH): pslverr=1 on the completing cycle, memory untouched, read returns 0.
- pslverr=0 whenever pready=0.
- Back-to-back: completion returns to IDLE; a setup phase on the next cycle is accepted with no idle gap. Read immediately after write to the same word returns the new data.
- Memory contents not cleared by reset; simulation start value undefined.

## Timing
- Reset (async assert): state=IDLE, cnt=0, prdata=0, pready=0, pslverr=0. Deassertion synchronous to next edge.
- Reset mid-transfer: transfer dropped, no write, outputs as above immediately.
- Transfer length: 1 setup + (WAIT_CYCLES+1) access cycles. WAIT_CYCLES=0 gives the standard two-cycle APB transfer.
- Write commit: rising edge ending the cycle where psel&penable&pready.
- Read data valid from first access cycle; held until next read setup or reset.
- cnt width 4 bits; never exceeds WAIT_CYCLES.

## Configuration
- APB_PSTRB_EN defined: write updates only bytes with pstrb[i]=1; pstrb=0 write is a legal no-op, pready normal, pslverr=0.
- Undefined: pstrb ignored, every write updates the full word (APB3 behaviour). Port remains present.

## Test plan
- DATA_W=32, WAIT=0: write 0xDEADBEEF to addr 0x10, read 0x10 -> pready in first access cycle both times, prdata=0xDEADBEEF, pslverr=0.
- WAIT=2: read addr 0x05 -> pready low for 2 access cycles, high on 3rd; write holds memory unchanged until 3rd-cycle edge.
- DEPTH=128: write 0x12345678 to addr 0x80, read 0x80 -> pslverr=1 with pready, prdata=0; addr 0x00 contents unchanged.
- APB_PSTRB_EN: write 0xFFFFFFFF, then 0x00000000 with pstrb=4'b0101 -> read 0xFF00FF00; without macro -> 0x00000000.
- Drop psel in WAIT=3 access cycle 2 of a write -> FSM IDLE, pready never high, target word unchanged; following setup accepted.
- Assert rst during access phase -> prdata/pready/pslverr 0 same cycle; penable=1 without setup after release -> pready stays 0.
